// File: rtl/magnetron_pwm_if.sv
// Front-panel, sensor and magnetron-drive signals of the cook controller.
// The controller uses the slave modport; the panel/bench side uses master.
interface magnetron_pwm_if #(
  parameter int POWER_W = 4
);
  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic               timer_done;
  logic [POWER_W-1:0] power_level;
  logic               mag_on;
  logic [1:0]         state;
  logic               busy;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done, power_level,
    input  mag_on, state, busy
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done, power_level,
    output mag_on, state, busy
  );
endinterface

// File: rtl/magnetron_pwm.sv
// Cook state machine with duty-cycle power control of the magnetron enable.
// Optional MAGNETRON_LOCKOUT_EN: a door opening while cooking enters LOCK until cleared.
module magnetron_pwm #(
  parameter int POWER_W = 4
) (
  input  logic            clk,
  input  logic            resetn,
  magnetron_pwm_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COOK  = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LOCK  = 2'b11;
`ifdef MAGNETRON_LOCKOUT_EN
  localparam logic [1:0] S_DOOR_OPEN = S_LOCK;
`else
  localparam logic [1:0] S_DOOR_OPEN = S_PAUSE;
`endif
  localparam logic [POWER_W-1:0] CNT_MAX = '1;
  localparam logic [POWER_W-1:0] CNT_ONE = {{(POWER_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [POWER_W-1:0] cnt_q, cnt_d;
  logic [POWER_W-1:0] duty_q, duty_d;
  logic               start_prev_q, stop_prev_q, clear_prev_q;
  logic               start_press, stop_press, clear_press;
  logic               pwm_on;

  // A press is the single cycle where the button is low but was high last sample.
  assign start_press = ~bus.startn & start_prev_q;
  assign stop_press  = ~bus.stopn  & stop_prev_q;
  assign clear_press = ~bus.clearn & clear_prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      duty_q       <= '0;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      start_prev_q <= bus.startn;
      stop_prev_q  <= bus.stopn;
      clear_prev_q <= bus.clearn;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_press && !stop_press && !clear_press &&
            bus.door_closed && !bus.timer_done)
          state_d = S_COOK;
      end
      S_COOK: begin
        if (clear_press || bus.timer_done) state_d = S_IDLE;
        else if (!bus.door_closed)         state_d = S_DOOR_OPEN;
        else if (stop_press)               state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (clear_press || bus.timer_done)                 state_d = S_IDLE;
        else if (bus.door_closed && !stop_press && start_press) state_d = S_COOK;
      end
      default: begin
        if (clear_press) state_d = S_IDLE;
      end
    endcase
  end

  // Period restarts on every COOK entry; duty only changes at period boundaries.
  always_comb begin
    cnt_d  = '0;
    duty_d = duty_q;
    if (state_d == S_COOK) begin
      if (state_q != S_COOK) begin
        duty_d = bus.power_level;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MAX) duty_d = bus.power_level;
      end
    end
  end

  // Door term stays combinational so an opening door kills the enable without a clock.
  always_comb begin
    pwm_on     = (duty_q == CNT_MAX) || (cnt_q < duty_q);
    bus.state  = state_q;
    bus.busy   = (state_q != S_IDLE);
    bus.mag_on = (state_q == S_COOK) && bus.door_closed && pwm_on;
  end
endmodule

// File: tb/tb_magnetron_pwm.sv
// Scenario bench for magnetron_pwm with a cycle-level reference model of the cook controller.
module tb_magnetron_pwm;
  localparam int W = 4;
  localparam int N = 1 << W;
  localparam int IDLE = 0, COOK = 1, PAUSE = 2, LOCK = 3;
`ifdef MAGNETRON_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  magnetron_pwm_if #(.POWER_W(W)) bus();
  magnetron_pwm #(.POWER_W(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: mode, cycles since cook entry, duty captured at each period start
  int m_state, m_age, m_duty;
  bit m_sh, m_th, m_ch;

  function automatic void model_reset();
    m_state = IDLE; m_age = 0; m_duty = 0;
    m_sh = 1'b1; m_th = 1'b1; m_ch = 1'b1;
  endfunction

  function automatic bit exp_mag();
    return (m_state == COOK) && (bus.door_closed == 1'b1) &&
           ((m_duty == N - 1) || ((m_age % N) < m_duty));
  endfunction

  // Apply inputs at a falling edge, clock once, advance the model, return at the next falling edge.
  task automatic step(input bit sn, input bit tn, input bit cn, input bit dc, input bit td, input int pl);
    bit sp, tp, cp;
    int nxt;
    bus.startn = sn; bus.stopn = tn; bus.clearn = cn;
    bus.door_closed = dc; bus.timer_done = td; bus.power_level = W'(pl);
    @(posedge clk);
    sp = !sn && m_sh; tp = !tn && m_th; cp = !cn && m_ch;
    m_sh = sn; m_th = tn; m_ch = cn;
    nxt = m_state;
    if (cp)                   nxt = IDLE;
    else if (m_state == LOCK) nxt = LOCK;
    else if (td)              nxt = IDLE;
    else if (!dc)             begin if (m_state == COOK) nxt = LOCK_EN ? LOCK : PAUSE; end
    else if (tp)              begin if (m_state == COOK) nxt = PAUSE; end
    else if (sp)              nxt = COOK;
    if (nxt == COOK && m_state != COOK) begin
      m_age = 0; m_duty = pl;
    end else if (nxt == COOK) begin
      m_age++;
      if (m_age % N == 0) m_duty = pl;
    end
    m_state = nxt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.startn = 1; bus.stopn = 1; bus.clearn = 1;
    bus.door_closed = 1; bus.timer_done = 0; bus.power_level = 4'd4;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL reset_mag got=%0b exp=0", bus.mag_on); end
    resetn = 1'b1;
    model_reset();
    step(1, 1, 1, 1, 0, 4);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%0d exp=0", bus.state); end
    $display("test_reset done");
  endtask

  task automatic test_power4();
    int highs;
    highs = 0;
    step(0, 1, 1, 1, 0, 4);
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL p4_enter got=%0d exp=1", bus.state); end
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step(1, 1, 1, 1, 0, 4);
      highs += int'(bus.mag_on);
      total++;
      if (bus.mag_on !== ((i % 16) < 4) || bus.mag_on !== exp_mag()) begin
        bad++; $display("FAIL p4_pattern cyc=%0d got=%0b exp=%0b", i, bus.mag_on, (i % 16) < 4);
      end
    end
    total++; if (highs != 8) begin bad++; $display("FAIL p4_high_count got=%0d exp=8", highs); end
    step(1, 1, 0, 1, 0, 4);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL p4_clear got=%0d exp=0", bus.state); end
    step(1, 1, 1, 1, 0, 4);
    $display("test_power4 done highs=%0d", highs);
  endtask

  task automatic test_full_and_zero();
    step(0, 1, 1, 1, 0, 15);
    for (int i = 0; i < 20; i++) begin
      total++; if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL full_on cyc=%0d got=%0b exp=1", i, bus.mag_on); end
      step(1, 1, 1, 1, 0, 15);
    end
    step(1, 1, 0, 1, 0, 15);
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (bus.mag_on !== 1'b0 || bus.state !== 2'b01) begin
        bad++; $display("FAIL zero_off cyc=%0d got_mag=%0b got_state=%0d exp_mag=0 exp_state=1", i, bus.mag_on, bus.state);
      end
      step(1, 1, 1, 1, 0, 0);
    end
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    $display("test_full_and_zero done");
  endtask

  task automatic test_door_open();
    logic [1:0] exp_st;
    step(0, 1, 1, 1, 0, 15);
    repeat (3) step(1, 1, 1, 1, 0, 15);
    total++; if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL door_pre got=%0b exp=1", bus.mag_on); end
    bus.door_closed = 1'b0;
    #1;
    total++; if (bus.mag_on !== 1'b0) begin bad++; $display("FAIL door_comb_drop got=%0b exp=0", bus.mag_on); end
    step(1, 1, 1, 0, 0, 15);
    exp_st = LOCK_EN ? 2'b11 : 2'b10;
    total++; if (bus.state !== exp_st) begin bad++; $display("FAIL door_state got=%0d exp=%0d", bus.state, exp_st); end
    step(1, 1, 1, 1, 0, 15);
    step(0, 1, 1, 1, 0, 15);
    exp_st = LOCK_EN ? 2'b11 : 2'b01;
    total++; if (bus.state !== exp_st) begin bad++; $display("FAIL door_resume got=%0d exp=%0d", bus.state, exp_st); end
    total++; if (bus.mag_on !== exp_mag()) begin bad++; $display("FAIL door_resume_mag got=%0b exp=%0b", bus.mag_on, exp_mag()); end
    step(1, 1, 0, 1, 0, 15);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL door_clear got=%0d exp=0", bus.state); end
    step(1, 1, 1, 1, 0, 15);
    $display("test_door_open done lock_en=%0b", LOCK_EN);
  endtask

  task automatic test_held_start();
    int entries;
    logic [1:0] prev;
    entries = 0;
    prev = bus.state;
    for (int i = 0; i < 20; i++) begin
      step(0, (i == 8) ? 1'b0 : 1'b1, 1, 1, 0, 4);
      if (bus.state === 2'b01 && prev !== 2'b01) entries++;
      prev = bus.state;
      total++; if (bus.state !== 2'(m_state)) begin bad++; $display("FAIL held_state cyc=%0d got=%0d exp=%0d", i, bus.state, m_state); end
    end
    total++; if (entries != 1) begin bad++; $display("FAIL held_entries got=%0d exp=1", entries); end
    total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL held_paused got=%0d exp=2", bus.state); end
    step(1, 1, 1, 1, 0, 4);
    step(0, 1, 1, 1, 0, 4);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1, 1, 1, 1, 0, 4);
      total++; if (bus.mag_on !== (i < 4)) begin bad++; $display("FAIL resume_restart cyc=%0d got=%0b exp=%0b", i, bus.mag_on, i < 4); end
    end
    step(1, 1, 0, 1, 0, 4);
    step(1, 1, 1, 1, 0, 4);
    $display("test_held_start done entries=%0d", entries);
  endtask

  task automatic test_clear_timer();
    step(0, 1, 1, 1, 0, 15);
    repeat (5) step(1, 1, 1, 1, 0, 15);
    step(1, 1, 0, 1, 1, 15);
    total++;
    if (bus.state !== 2'b00 || bus.busy !== 1'b0 || bus.mag_on !== 1'b0) begin
      bad++; $display("FAIL clear_timer got_state=%0d got_busy=%0b got_mag=%0b exp=0/0/0", bus.state, bus.busy, bus.mag_on);
    end
    step(1, 1, 1, 1, 0, 15);
    step(0, 1, 1, 1, 0, 15);
    step(1, 1, 1, 1, 1, 15);
    total++;
    if (bus.state !== 2'b00 || bus.mag_on !== 1'b0) begin
      bad++; $display("FAIL timer_only got_state=%0d got_mag=%0b exp=0/0", bus.state, bus.mag_on);
    end
    step(0, 1, 1, 1, 1, 15);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL start_timer_done got=%0d exp=0", bus.state); end
    step(1, 1, 1, 1, 0, 15);
    $display("test_clear_timer done");
  endtask

  task automatic test_duty_change();
    bit exp;
    step(0, 1, 1, 1, 0, 4);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step(1, 1, 1, 1, 0, (i >= 6) ? 8 : 4);
      exp = (i < 16) ? (i < 4) : ((i - 16) < 8);
      total++;
      if (bus.mag_on !== exp || bus.mag_on !== exp_mag()) begin
        bad++; $display("FAIL duty_change cyc=%0d got=%0b exp=%0b", i, bus.mag_on, exp);
      end
    end
    step(1, 1, 0, 1, 0, 8);
    step(1, 1, 1, 1, 0, 8);
    $display("test_duty_change done");
  endtask

  task automatic test_random();
    bit sn, tn, cn, dc, td;
    int pl;
    for (int i = 0; i < 400; i++) begin
      sn = ($urandom_range(0, 3) != 0);
      tn = ($urandom_range(0, 7) != 0);
      cn = ($urandom_range(0, 15) != 0);
      dc = ($urandom_range(0, 9) != 0);
      td = ($urandom_range(0, 19) == 0);
      pl = $urandom_range(0, N - 1);
      step(sn, tn, cn, dc, td, pl);
      total++;
      if (bus.state !== 2'(m_state) || bus.busy !== (m_state != IDLE) || bus.mag_on !== exp_mag()) begin
        bad++;
        $display("FAIL random cyc=%0d got_state=%0d got_busy=%0b got_mag=%0b exp_state=%0d exp_busy=%0b exp_mag=%0b",
                 i, bus.state, bus.busy, bus.mag_on, m_state, m_state != IDLE, exp_mag());
      end
    end
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    step(0, 1, 1, 1, 0, 15);
    repeat (3) step(1, 1, 1, 1, 0, 15);
    total++; if (bus.mag_on !== 1'b1) begin bad++; $display("FAIL async_pre got=%0b exp=1", bus.mag_on); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (bus.mag_on !== 1'b0 || bus.state !== 2'b00 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL async_reset got_mag=%0b got_state=%0d got_busy=%0b exp=0/0/0", bus.mag_on, bus.state, bus.busy);
    end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step(1, 1, 1, 1, 0, 15);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL async_after got=%0d exp=0", bus.state); end
    step(0, 1, 1, 1, 0, 15);
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL async_restart got=%0d exp=1", bus.state); end
    $display("test_async_reset done");
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_power4();
    test_full_and_zero();
    test_door_open();
    test_held_start();
    test_clear_timer();
    test_duty_change();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/magnetron_pwm.md
# magnetron_pwm

Clocked successor to the microwave magnetron enable path: replaces the set/reset latch with a synchronous cook state machine and adds power-level control by duty-cycle modulation of `mag_on` over a fixed PWM period. It takes the same active-low front-panel buttons, the door switch and the cook-timer done flag. It drives the magnetron enable directly.

## Interface
- `POWER_W`, default 4: power-level width; PWM period is fixed at 2**`POWER_W` clock cycles.
- `clk` input 1: system clock, all state on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `startn` input 1: start button, active-low level.
- `stopn` input 1: stop/pause button, active-low level.
- `clearn` input 1: clear/cancel button, active-low level.
- `door_closed` input 1: 1 = door closed.
- `timer_done` input 1: 1 = cook timer expired.
- `power_level` input `POWER_W`: requested power; 0 = off, all-ones = continuous.
- `mag_on` output 1: magnetron enable.
- `state` output 2: IDLE=00, COOK=01, PAUSE=10, LOCK=11.
- `busy` output 1: `state` != IDLE.

## Operation
- Button press = falling edge: one register per button holds the previous sample, reset to 1. Press is active for the cycle where the current input is 0 and the previous sample is 1. A held button produces exactly one press.
- Transitions are evaluated each edge. Priority, highest first: clear press, `timer_done`=1, door open, stop press, start press.
- IDLE: start press with `door_closed`=1 and `timer_done`=0 -> COOK. Start with door open or timer done is ignored.
- COOK: clear press -> IDLE; `timer_done` -> IDLE; `door_closed`=0 -> PAUSE (LOCK when the macro is defined); stop press -> PAUSE.
- PAUSE: clear press -> IDLE; `timer_done` -> IDLE; start press with door closed -> COOK. Start with door open stays in PAUSE.
- LOCK: only a clear press leaves it (-> IDLE). All other inputs are ignored.
- PWM counter `cnt` (`POWER_W` bits): 0 in every state except COOK. Forced to 0 on entry to COOK. In COOK it increments each cycle and wraps from 2**`POWER_W`-1 to 0.
- `duty` register: loaded from `power_level` on COOK entry and at every wrap to 0. Mid-period changes to `power_level` take effect at the next period boundary.
- `pwm_on` = 1 when `duty` is all-ones; otherwise `pwm_on` = (`cnt` < `duty`).
- `mag_on` = (`state`==COOK) & `door_closed` & `pwm_on`. The door term is combinational so that door opening removes `mag_on` with no clock delay (safety). All other terms are registered, so `mag_on` is glitch-free.

## Timing
- Reset values: `state`=IDLE, `cnt`=0, `duty`=0, button history=1; hence `mag_on`=0 and `busy`=0.
- Start press sampled at edge k -> `state`=COOK, `cnt`=0 after edge k. `mag_on` is high in the cycle after edge k when the sampled `power_level` != 0.
- With `duty`=D (0 < D < all-ones): `mag_on` high for D cycles, then low for 2**`POWER_W`-D cycles, repeating.
- Stop press or `timer_done` at edge k: `mag_on` is low after edge k.
- PAUSE -> COOK restarts the PWM period from `cnt`=0 and re-samples `power_level`.
- Asserting `resetn` mid-cook returns all outputs to reset values immediately, with no clock required.

## Configuration
- `MAGNETRON_LOCKOUT_EN` defined: a door opening during COOK enters LOCK. Cooking cannot resume until a clear press, after which a fresh start from IDLE is required.
- Not defined: LOCK is unreachable, the door-open transition goes to PAUSE, and a start press with the door closed resumes cooking.

## Test plan
- Reset, then start press with door closed, `power_level`=4, `POWER_W`=4 -> `state`=01; `mag_on` 4 cycles high, 12 low, repeating.
- `power_level`=15 -> `mag_on` continuously high in COOK. `power_level`=0 -> `mag_on` stays 0 while `state`=01.
- Door opens mid-cook -> `mag_on` drops in the same cycle. `state`=10 without macro, 11 with macro. Start then resumes (no macro) or is ignored until clear (macro).
- Hold `startn` low for 20 cycles in IDLE -> exactly one transition to COOK. Stop press -> PAUSE; start press -> COOK with `cnt` restarting at 0.
- Clear press and `timer_done`=1 in the same cycle during COOK -> IDLE, `busy`=0, `mag_on`=0. Change `power_level` 4->8 mid-period -> new duty appears only after the next wrap.
- Pull `resetn` low mid-cook between clock edges -> `mag_on`=0, `state`=00 immediately.
